// File: rtl/wb_sram_tester.sv
// wb_sram_tester: Wishbone master that exercises a RAM window.
// It writes a seeded pattern to N words, reads them back, counts mismatches
// and reports pass/fail. Every transaction is single and non-pipelined, with
// one idle cycle between transactions and a per-transaction ack timeout.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   start                   one-cycle run request (ignored while busy)
//   num_words               word count N, 0..2^ADDR_WIDTH
//   seed                    pattern seed; P(i) = seed ^ (i * 32'h0101_0101)
//   wbm_cyc_o .. wbm_ack_i  Wishbone classic master port
//   busy, done, pass        run status (done/pass are sticky)
//   timeout                 sticky: some transaction never got an ack
//   err_count               saturating count of read mismatches
//   first_err_addr          word index of the first mismatch
//
// state  | meaning
// IDLE   | waiting for start
// WR_REQ | write cycle on the bus, waiting for ack
// WR_GAP | one idle bus cycle after a write
// RD_REQ | read cycle on the bus, waiting for ack
// RD_GAP | one idle bus cycle after a read
// FIN    | publish done/pass, then back to IDLE
module wb_sram_tester #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 8,
  parameter int          TIMEOUT    = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [31:0]           seed,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic [31:0]           wbm_adr_o,
  output logic [31:0]           wbm_dat_o,
  input  logic [31:0]           wbm_dat_i,
  input  logic                  wbm_ack_i,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FIN} state_t;

  localparam int                  TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0]       TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0] ONE      = 1;

  state_t              state;
  logic [ADDR_WIDTH:0] idx;
  logic [ADDR_WIDTH:0] n_q;
  logic [31:0]         seed_q;
  logic [TW-1:0]       tmr;

  function automatic logic [31:0] pattern(input logic [31:0] s, input logic [ADDR_WIDTH:0] i);
    logic [31:0] iz;
    iz = '0;
    iz[ADDR_WIDTH:0] = i;
    return s ^ (iz * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] word_addr(input logic [ADDR_WIDTH:0] i);
    logic [31:0] iz;
    iz = '0;
    iz[ADDR_WIDTH-1:0] = i[ADDR_WIDTH-1:0];
    return BASE_ADDR | iz;
  endfunction

  // idx advances on the ack edge, so in the gap states it already names the
  // next word and the compare against n_q decides whether the phase is over.
  // The timeout timer is loaded whenever stb rises and counts down while stb
  // is high; reaching zero without an ack ends the run.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state          <= IDLE;
      idx            <= '0;
      n_q            <= '0;
      seed_q         <= '0;
      tmr            <= '0;
      wbm_cyc_o      <= 1'b0;
      wbm_stb_o      <= 1'b0;
      wbm_we_o       <= 1'b0;
      wbm_sel_o      <= 4'h0;
      wbm_adr_o      <= '0;
      wbm_dat_o      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_q            <= num_words;
            seed_q         <= seed;
            idx            <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            busy           <= 1'b1;
            if (num_words == '0) begin
              state <= FIN;
            end else begin
              state     <= WR_REQ;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= 1'b1;
              wbm_sel_o <= 4'hF;
              wbm_adr_o <= BASE_ADDR;
              wbm_dat_o <= seed;
              tmr       <= TMR_LOAD;
            end
          end
        end

        WR_REQ, RD_REQ: begin
          if (wbm_ack_i || tmr == '0) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
          end
          if (wbm_ack_i) begin
            idx <= idx + ONE;
            if (state == RD_REQ) begin
              state <= RD_GAP;
              if (wbm_dat_i != pattern(seed_q, idx)) begin
                if (err_count != '1) err_count <= err_count + 16'd1;
                if (err_count == '0) first_err_addr <= idx[ADDR_WIDTH-1:0];
              end
            end else begin
              state <= WR_GAP;
            end
          end else if (tmr == '0) begin
            timeout <= 1'b1;
            state   <= FIN;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        WR_GAP: begin
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          wbm_sel_o <= 4'hF;
          tmr       <= TMR_LOAD;
          if (idx == n_q) begin
            idx       <= '0;
            state     <= RD_REQ;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= BASE_ADDR;
            wbm_dat_o <= '0;
          end else begin
            state     <= WR_REQ;
            wbm_we_o  <= 1'b1;
            wbm_adr_o <= word_addr(idx);
            wbm_dat_o <= pattern(seed_q, idx);
          end
        end

        RD_GAP: begin
          if (idx == n_q) begin
            state <= FIN;
          end else begin
            state     <= RD_REQ;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'hF;
            wbm_adr_o <= word_addr(idx);
            wbm_dat_o <= '0;
            tmr       <= TMR_LOAD;
          end
        end

        FIN: begin
          // start is deliberately not looked at here
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_count == '0) && !timeout;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_tester.sv
// Scoreboard bench for wb_sram_tester: stimulus pushes expected bus
// transactions and run results into queues; a monitor pops and compares
// them whenever the DUT completes a transaction or raises done.
module tb_wb_sram_tester;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          AW   = 8;
  localparam int          TO   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic [31:0]   seed = '0;
  logic          cyc, stb, we, ack;
  logic [3:0]    sel;
  logic [31:0]   adr, dat_o, dat_i;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;

  wb_sram_tester #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .num_words(num_words), .seed(seed),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr));

  always #5 clk = ~clk;

  typedef struct {logic w; logic [31:0] a; logic [31:0] d;} txn_t;
  typedef struct {logic p; logic t; logic [15:0] e; logic [7:0] f; int rises;} res_t;

  txn_t exp_bus[$];
  res_t exp_res[$];

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- RAM model (1-cycle ack) ----------------
  logic [31:0]  mem [256];
  logic [255:0] bad_mask = '0;
  int           hang_from = -1;
  int           wr_cnt;

  initial begin
    ack = 1'b0; dat_i = '0; wr_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!busy) wr_cnt = 0;
      if (cyc && stb && !ack && !(hang_from >= 0 && we && wr_cnt >= hang_from)) begin
        ack = 1'b1;
        if (we) begin
          mem[adr[7:0]] = dat_o;
          wr_cnt++;
          dat_i = '0;
        end else begin
          dat_i = mem[adr[7:0]] ^ {31'd0, bad_mask[adr[7:0]]};
        end
      end else begin
        ack = 1'b0; dat_i = '0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic rst_at_edge = 1'b0;
  always @(posedge clk) rst_at_edge <= rst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event, expected none (t=%0t)", name, $time);
  endtask

  int   cyc_n = 0, last_txn = -1, run_len = 0, rises = 0;
  logic prev_stb = 1'b0, prev_done = 1'b0, acked = 1'b0;

  always @(negedge clk) begin
    txn_t t;
    res_t r;
    cyc_n++;
    if (rst_at_edge) begin
      chk("reset_bus", {25'd0, cyc, stb, we, sel, adr}, 64'd0);
      chk("reset_wdata", {32'd0, dat_o}, 64'd0);
      chk("reset_status", {36'd0, busy, done, pass, timeout, err_count, first_err_addr}, 64'd0);
      exp_bus.delete();
      exp_res.delete();
      prev_stb = 1'b0; prev_done = 1'b0; acked = 1'b0;
      run_len = 0; rises = 0; last_txn = -1;
    end else begin
      if (stb) begin
        if (!prev_stb) rises++;
        run_len++;
        chk("sel_during_stb", {60'd0, sel}, 64'hF);
      end
      if (stb && ack) begin
        acked = 1'b1;
        if (exp_bus.size() == 0) fail_evt("extra_transaction");
        else begin
          t = exp_bus.pop_front();
          chk("txn_we", {63'd0, we}, {63'd0, t.w});
          chk("txn_adr", {32'd0, adr}, {32'd0, t.a});
          chk("txn_dat", {32'd0, dat_o}, {32'd0, t.d});
        end
        if (last_txn >= 0) chk("txn_spacing", 64'(cyc_n - last_txn), 64'd2);
        last_txn = cyc_n;
      end
      if (!stb && prev_stb) begin
        chk("stb_high_cycles", 64'(run_len), acked ? 64'd1 : 64'(TO));
        chk("idle_cyc_sel", {59'd0, cyc, sel}, 64'd0);
        run_len = 0;
        acked = 1'b0;
      end
      if (done && !prev_done) begin
        if (exp_res.size() == 0) fail_evt("extra_done");
        else begin
          r = exp_res.pop_front();
          chk("pass", {63'd0, pass}, {63'd0, r.p});
          chk("timeout", {63'd0, timeout}, {63'd0, r.t});
          chk("err_count", {48'd0, err_count}, {48'd0, r.e});
          chk("first_err_addr", {56'd0, first_err_addr}, {56'd0, r.f});
          chk("stb_assertions", 64'(rises), 64'(r.rises));
          chk("busy_at_done", {63'd0, busy}, 64'd0);
          chk("missing_txns", 64'(exp_bus.size()), 64'd0);
        end
        rises = 0;
        last_txn = -1;
      end
      prev_stb = stb;
      prev_done = done;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] pat(input logic [31:0] s, input int i);
    return s ^ (32'(i) * 32'h0101_0101);
  endfunction

  task automatic push_txn(input logic w, input int i, input logic [31:0] d);
    txn_t t;
    t.w = w; t.a = BASE | 32'(i); t.d = d;
    exp_bus.push_back(t);
  endtask

  task automatic push_res(input logic p, input logic t, input int e, input int f, input int rs);
    res_t r;
    r.p = p; r.t = t; r.e = 16'(e); r.f = 8'(f); r.rises = rs;
    exp_res.push_back(r);
  endtask

  task automatic expect_run(input int n, input logic [31:0] s, input int hang, input logic [255:0] bad);
    int nerr, first;
    nerr = 0; first = -1;
    if (hang >= 0 && hang < n) begin
      for (int i = 0; i < hang; i++) push_txn(1'b1, i, pat(s, i));
      push_res(1'b0, 1'b1, 0, 0, hang + 1);
    end else begin
      for (int i = 0; i < n; i++) push_txn(1'b1, i, pat(s, i));
      for (int i = 0; i < n; i++) begin
        push_txn(1'b0, i, 32'd0);
        if (bad[i]) begin
          nerr++;
          if (first < 0) first = i;
        end
      end
      push_res(nerr == 0, 1'b0, nerr, (first < 0) ? 0 : first, 2 * n);
    end
  endtask

  task automatic start_run(input int n, input logic [31:0] s);
    @(negedge clk);
    num_words = (AW+1)'(n);
    seed = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      $display("FAIL %s: done=%0b after %0d cycles, expected 1", name, done, k);
      $fatal(1);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic found;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic run, hand-computed vectors; a start mid-run must be ignored.
    push_txn(1'b1, 0, 32'hA5A5_0000);
    push_txn(1'b1, 1, 32'hA4A4_0101);
    push_txn(1'b1, 2, 32'hA7A7_0202);
    push_txn(1'b1, 3, 32'hA6A6_0303);
    for (int i = 0; i < 4; i++) push_txn(1'b0, i, 32'd0);
    push_res(1'b1, 1'b0, 0, 0, 8);
    start_run(4, 32'hA5A5_0000);
    repeat (3) @(negedge clk);
    num_words = 1; seed = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, "done_basic");

    // Bit 0 corrupted on read of index 2.
    bad_mask = '0; bad_mask[2] = 1'b1;
    expect_run(4, 32'hA5A5_0000, -1, bad_mask);
    start_run(4, 32'hA5A5_0000);
    wait_done(200, "done_corrupt2");

    // Two corrupted words: first error must stay at index 0.
    bad_mask = '0; bad_mask[0] = 1'b1; bad_mask[2] = 1'b1;
    expect_run(3, 32'hFFFF_FFFF, -1, bad_mask);
    start_run(3, 32'hFFFF_FFFF);
    wait_done(200, "done_corrupt02");
    bad_mask = '0;

    // No ack from the third write on: timeout, no read phase.
    hang_from = 2;
    expect_run(4, 32'hA5A5_0000, 2, bad_mask);
    start_run(4, 32'hA5A5_0000);
    wait_done(200, "done_timeout");
    hang_from = -1;

    // N=0, start held into the FIN cycle: exactly one empty run.
    push_res(1'b1, 1'b0, 0, 0, 0);
    @(negedge clk);
    num_words = '0; seed = 32'h1234_5678; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(50, "done_n0");

    // Full window.
    expect_run(256, 32'h1234_5678, -1, bad_mask);
    start_run(256, 32'h1234_5678);
    wait_done(3000, "done_full");

    // Reset while the read of index 1 is being acked.
    expect_run(4, 32'h0F0F_F0F0, -1, bad_mask);
    start_run(4, 32'h0F0F_F0F0);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (stb && !we && adr == (BASE | 32'd1) && ack) found = 1'b1;
    end
    if (!found) begin
      $display("FAIL reset_point: read of index 1 not seen, expected within 200 cycles");
      $fatal(1);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    expect_run(4, 32'h0F0F_F0F0, -1, bad_mask);
    start_run(4, 32'h0F0F_F0F0);
    wait_done(200, "done_after_reset");

    // start coincident with reset must not launch a run.
    rst = 1'b1; start = 1'b1; num_words = 4;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (10) @(negedge clk);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
